// File: rtl/sram_bist_pkg.sv
`default_nettype none
//==============================================================================
// Module  : sram_bist_pkg
// Brief   : Shared types and per-element March C- tables for the SRAM BIST.
// Revision: 1.0 - initial release
//==============================================================================
package sram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } march_state_e;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    localparam logic [31:0] c_bg_default = 32'h5555_5555;

    // Bit n of each table describes element Mn.
    // M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 dn(r0,w1) M4 dn(r1,w0) M5 dn(r0)
    localparam logic [5:0] c_elem_down   = 6'b111000;
    localparam logic [5:0] c_elem_rd     = 6'b111110;
    localparam logic [5:0] c_elem_rd_inv = 6'b010100;
    localparam logic [5:0] c_elem_wr     = 6'b011111;
    localparam logic [5:0] c_elem_wr_inv = 6'b001010;

    function automatic march_elem_e next_elem(input march_elem_e e);
        return (e == M5) ? M0 : march_elem_e'(e + 3'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bist_if.sv
`default_nettype none
//==============================================================================
// Module  : sram_bist_if
// Brief   : Pin bundle between the BIST engine and the SRAM macro.
// Revision: 1.0 - initial release
//==============================================================================
interface sram_bist_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 4
);
    logic                   sram_we;
    logic [WMASK_WIDTH-1:0] sram_wmask;
    logic [ADDR_WIDTH-1:0]  sram_addr;
    logic [DATA_WIDTH-1:0]  sram_din;
    logic [DATA_WIDTH-1:0]  sram_dout;

    modport master (
        output sram_we,
        output sram_wmask,
        output sram_addr,
        output sram_din,
        input  sram_dout
    );

    modport slave (
        input  sram_we,
        input  sram_wmask,
        input  sram_addr,
        input  sram_din,
        output sram_dout
    );
endinterface
`default_nettype wire

// File: rtl/sram_bist_addr_gen.sv
`default_nettype none
//==============================================================================
// Module  : sram_bist_addr_gen
// Brief   : Up/down March address counter with load, step and last flag.
// Revision: 1.0 - initial release
//==============================================================================
module sram_bist_addr_gen
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_load_down,
    input  logic                  i_step,
    input  logic                  i_down,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_addr;

    // Load wins over step so an element change lands on the new start address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_down ? '1 : '0;
        end else if (i_step) begin
            r_addr <= i_down ? (r_addr - ADDR_WIDTH'(1)) : (r_addr + ADDR_WIDTH'(1));
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_down ? (r_addr == '0) : (r_addr == '1);

endmodule
`default_nettype wire

// File: rtl/sram_bist_march.sv
`default_nettype none
//==============================================================================
// Module  : sram_bist_march
// Brief   : March C- BIST engine driving one SRAM macro, with first-fail capture.
// Revision: 1.0 - initial release
//==============================================================================
module sram_bist_march
    import sram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    WMASK_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] BG          = DATA_WIDTH'(c_bg_default),
    parameter int                    CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    sram_bist_if.master           sram
);

    march_state_e r_state, w_state_nxt;
    march_elem_e  r_elem, w_elem_nxt;
    logic         r_phase, w_phase_nxt;
    logic         r_fin, w_fin_nxt;
    logic         w_issue, w_clear, w_done_nxt;

    logic                  w_ag_load, w_ag_load_down, w_ag_step, w_ag_down;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_last;

    logic                  w_two_op, w_is_read, w_elem_end, w_final, w_op_we;
    logic [DATA_WIDTH-1:0] w_rd_pat, w_wr_pat;

    logic                   r_we;
    logic [WMASK_WIDTH-1:0] r_wmask;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_din;
    logic                   r_rd;
    logic [DATA_WIDTH-1:0]  r_exp;

    logic                  r_cmp_valid;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic                  w_miscompare;

    logic                  r_done, r_fail;
    logic [CNT_WIDTH-1:0]  r_err_count;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;

    sram_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_ag_load),
        .i_load_down (w_ag_load_down),
        .i_step      (w_ag_step),
        .i_down      (w_ag_down),
        .o_addr      (w_addr),
        .o_last      (w_last)
    );

    // The op pointer (r_elem, address, r_phase) names the op issued at the next edge.
    assign w_ag_down  = c_elem_down[r_elem];
    assign w_two_op   = c_elem_rd[r_elem] & c_elem_wr[r_elem];
    assign w_is_read  = c_elem_rd[r_elem] & ~r_phase;
    assign w_elem_end = w_last & (~w_two_op | r_phase);
    assign w_final    = w_elem_end & (r_elem == M5);
    assign w_rd_pat   = c_elem_rd_inv[r_elem] ? ~BG : BG;
    assign w_wr_pat   = c_elem_wr_inv[r_elem] ? ~BG : BG;

    // r_fin marks that the final read is on the pins; RUN then hands over to DRAIN.
    assign w_issue = ((r_state == IDLE) & start) | ((r_state == RUN) & ~r_fin);
    assign w_op_we = w_issue & ~w_is_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_elem  <= M0;
            r_phase <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_phase <= w_phase_nxt;
            r_fin   <= w_fin_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                if (r_fin) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // After the last op of M5 the pointer reloads M0/addr 0, so IDLE always sits at the start.
    always_comb begin
        w_elem_nxt     = r_elem;
        w_phase_nxt    = r_phase;
        w_fin_nxt      = 1'b0;
        w_ag_load      = 1'b0;
        w_ag_load_down = 1'b0;
        w_ag_step      = 1'b0;
        if (w_issue) begin
            w_fin_nxt = w_final;
            if (w_two_op && !r_phase) begin
                w_phase_nxt = 1'b1;
            end else begin
                w_phase_nxt = 1'b0;
                if (w_elem_end) begin
                    w_ag_load      = 1'b1;
                    w_elem_nxt     = next_elem(r_elem);
                    w_ag_load_down = c_elem_down[w_elem_nxt];
                end else begin
                    w_ag_step = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_rd    <= 1'b0;
            r_exp   <= '0;
        end else begin
            r_we    <= w_op_we;
            r_wmask <= w_op_we ? '1 : '0;
            r_addr  <= w_issue ? w_addr : '0;
            r_din   <= w_op_we ? w_wr_pat : '0;
            r_rd    <= w_issue & w_is_read;
            r_exp   <= w_rd_pat;
        end
    end

    // Read data appears the cycle after the macro samples the read, hence one pipe stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_exp   <= '0;
        end else begin
            r_cmp_valid <= r_rd;
            r_cmp_addr  <= r_addr;
            r_cmp_exp   <= r_exp;
        end
    end

    assign w_miscompare = r_cmp_valid & (sram.sram_dout != r_cmp_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_err_count <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_clear) begin
                r_fail      <= 1'b0;
                r_err_count <= '0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
            end else if (w_miscompare) begin
                r_fail <= 1'b1;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + CNT_WIDTH'(1);
                end
                if (!r_fail) begin
                    r_fail_addr <= r_cmp_addr;
                    r_fail_data <= sram.sram_dout;
                end
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign fail      = r_fail;
    assign err_count = r_err_count;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

    assign sram.sram_we    = r_we;
    assign sram.sram_wmask = r_wmask;
    assign sram.sram_addr  = r_addr;
    assign sram.sram_din   = r_din;

endmodule
`default_nettype wire

// File: tb/tb_sram_bist_march.sv
`default_nettype none
//==============================================================================
// Module  : tb_sram_bist_march
// Brief   : Scoreboard bench for sram_bist_march with a behavioural SRAM and fault model.
// Revision: 1.0 - initial release
//==============================================================================
module tb_sram_bist_march;

    localparam logic [31:0] BG = 32'h5555_5555;

    typedef struct {
        logic [42:0] bits;   // {we, wmask, addr, din}
        longint      cyc;
    } op_t;

    typedef struct {
        logic        fail;
        logic [7:0]  err;
        logic [5:0]  faddr;
        logic [31:0] fdata;
        longint      cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, fail;
    logic [7:0]  err_count;
    logic [5:0]  fail_addr;
    logic [31:0] fail_data;

    longint cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    int f_mode = 0;
    int f_addr = 0;
    int f_bit = 0;

    op_t  opq[$];
    res_t resq[$];
    op_t  mon_op;
    res_t mon_res;

    logic [31:0] mem [64];

    sram_bist_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WMASK_WIDTH(4)) u_if ();

    sram_bist_march #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (6),
        .WMASK_WIDTH (4),
        .BG          (BG),
        .CNT_WIDTH   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .sram      (u_if)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // mode 1: bit fb of address fa reads back as 1; mode 2: every read returns 0
    function automatic logic [31:0] fault_read(input int mode, input int fa, input int fb,
                                               input int a, input logic [31:0] v);
        if (mode == 2) return 32'h0;
        if (mode == 1 && a == fa) return v | (32'h1 << fb);
        return v;
    endfunction

    function automatic string elem_ops(input int e);
        case (e)
            0:       return "w0";
            1:       return "r0w1";
            2:       return "r1w0";
            3:       return "r0w1";
            4:       return "r1w0";
            default: return "r0";
        endcase
    endfunction

    // Behavioural SRAM macro; dout after a write is garbage and must never be compared.
    initial for (int i = 0; i < 64; i++) mem[i] = $urandom;

    always @(posedge clk) begin
        if (u_if.sram_we) begin
            for (int b = 0; b < 4; b++)
                if (u_if.sram_wmask[b]) mem[u_if.sram_addr][8*b +: 8] <= u_if.sram_din[8*b +: 8];
            u_if.sram_dout <= $urandom;
        end else begin
            u_if.sram_dout <= fault_read(f_mode, f_addr, f_bit, int'(u_if.sram_addr), mem[u_if.sram_addr]);
        end
    end

    // Reference: walk March C- over an array memory, queue every op and the final results.
    task automatic build_expect(input int mode, input int fa, input int fb, input longint base);
        logic [31:0] m [64];
        int          nerr;
        bit          seen;
        logic [5:0]  fad;
        logic [31:0] fdat;
        longint      c;
        res_t        r;
        nerr = 0; seen = 0; fad = '0; fdat = '0; c = base + 1;
        for (int i = 0; i < 64; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 64; i++) begin
                string s;
                int a;
                s = elem_ops(e);
                a = (e >= 3) ? 63 - i : i;
                for (int k = 0; k < s.len(); k += 2) begin
                    logic [31:0] pat;
                    logic [31:0] got;
                    op_t o;
                    pat = (s[k+1] == "1") ? ~BG : BG;
                    if (s[k] == "r") begin
                        got = fault_read(mode, fa, fb, a, m[a]);
                        if (got !== pat) begin
                            if (!seen) begin seen = 1; fad = 6'(a); fdat = got; end
                            nerr++;
                        end
                        o.bits = {1'b0, 4'h0, 6'(a), 32'h0};
                    end else begin
                        m[a] = pat;
                        o.bits = {1'b1, 4'hF, 6'(a), pat};
                    end
                    o.cyc = c;
                    opq.push_back(o);
                    c++;
                end
            end
        end
        r.fail = (nerr > 0);
        r.err = (nerr > 255) ? 8'hFF : 8'(nerr);
        r.faddr = fad;
        r.fdata = fdat;
        r.cyc = base + 642;
        resq.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                if (opq.size() != 0) begin
                    mon_op = opq.pop_front();
                    check("op_cycle", 64'(cyc), 64'(mon_op.cyc));
                    check("op_pins", 64'({u_if.sram_we, u_if.sram_wmask, u_if.sram_addr, u_if.sram_din}),
                          64'(mon_op.bits));
                end else begin
                    check("drain_we", 64'(u_if.sram_we), 64'(0));
                end
            end
            if (done) begin
                if (resq.size() == 0) begin
                    check("unexpected_done", 64'(1), 64'(0));
                end else begin
                    mon_res = resq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_res.cyc));
                    check("fail", 64'(fail), 64'(mon_res.fail));
                    check("err_count", 64'(err_count), 64'(mon_res.err));
                    check("fail_addr", 64'(fail_addr), 64'(mon_res.faddr));
                    check("fail_data", 64'(fail_data), 64'(mon_res.fdata));
                end
            end
        end
    end

    task automatic run_test(input int mode, input int fa, input int fb,
                            input bit poke, input bit b2b, input bit rst300);
        longint base;
        bit     got_done;
        got_done = 0;
        if (!b2b) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        f_mode = mode; f_addr = fa; f_bit = fb;
        start = 1'b1;
        base = cyc;
        build_expect(mode, fa, fb, base);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 700 && !got_done; i++) begin
            @(posedge clk);
            #1;
            start = poke && (cyc == base + 100);
            if (rst300 && cyc == base + 300) begin
                @(negedge clk);
                #2;
                check("we_before_reset", 64'(u_if.sram_we), 64'(1));
                rst_n = 1'b0;
                #1;
                check("we_async_reset", 64'(u_if.sram_we), 64'(0));
                check("busy_async_reset", 64'(busy), 64'(0));
                check("addr_async_reset", 64'(u_if.sram_addr), 64'(0));
                opq.delete();
                resq.delete();
                @(posedge clk);
                #3 rst_n = 1'b1;
                return;
            end
            if (done) got_done = 1;
        end
        if (!got_done) check("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_fail", 64'(fail), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        check("rst_fail_addr", 64'(fail_addr), 64'(0));
        check("rst_fail_data", 64'(fail_data), 64'(0));
        check("rst_sram_pins", 64'({u_if.sram_we, u_if.sram_wmask, u_if.sram_addr, u_if.sram_din}), 64'(0));

        run_test(0, 0, 0, 0, 0, 0);      // clean pass
        run_test(1, 42, 7, 0, 0, 0);     // stuck bit 7 at 0x2A
        run_test(2, 0, 0, 0, 0, 0);      // dout always zero, counter saturates
        run_test(0, 0, 0, 1, 0, 0);      // start while busy is ignored
        run_test(0, 0, 0, 0, 1, 0);      // restart in the done cycle
        run_test(0, 0, 0, 0, 0, 1);      // reset mid-test
        repeat (5) @(negedge clk);
        check("post_reset_err_count", 64'(err_count), 64'(0));
        check("post_reset_fail", 64'(fail), 64'(0));
        run_test(0, 0, 0, 0, 0, 0);      // clean pass after reset
        for (int t = 0; t < 4; t++) begin
            int mode;
            mode = (t == 3) ? 2 : 1;
            run_test(mode, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), 0, 0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("ops_drained", 64'(opq.size()), 64'(0));
        check("results_drained", 64'(resq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
